multi_zone_stove: RTL
=====================

# multi_zone_stove

Parametrised successor of the two-surface stove controller. Drives ZONES cooking zones, each with a power level of 0..MAX_LEVEL, a per-zone residual-heat ("H") timer that keeps running after power-off, and a child lock with an abortable arm sequence. Sits between the debounced button front end and the board's active-low 7-segment displays, with one digit per zone.

## Interface
- ZONES, 4: number of zones/digits (1..8)
- MAX_LEVEL, 9: highest power level (1..9)
- CLK_HZ, 50_000_000: clk cycles per second
- LOCK_SHOW_S, 2: seconds "L" is shown after locking
- HOT_S, 10: residual-heat hold time, seconds

Ports:
- clk  in  1  system clock
- async_reset  in  1  asynchronous, active-low reset
- power_toggle  in  1  one-cycle pulse
- zone_toggle  in  ZONES  one-cycle pulses; bit i toggles selection of zone i
- level_inc  in  1  one-cycle pulse
- level_dec  in  1  one-cycle pulse
- lock_hold  in  1  one-cycle pulse; three-second press already qualified upstream
- seg_out  out  8*ZONES  byte i = {dp_n, g..a active-low} for zone i
- hot_flags  out  ZONES  residual heat active per zone
- locked  out  1  child lock state

## Operation
- Registers: state, sel[ZONES], level[i] (4 bits), hot[i], hot_sec[i] (ceil(log2(HOT_S+1)) bits), locked, 1 s prescaler, state cycle timer.
- Glyphs (7 bits): digits 0-9 = 40,79,24,30,19,12,02,78,00,10 (hex); H=09; L=47; blank=7F. The byte is {~sel[i], glyph}.
- States: OFF, ON, LOCK_ARM, LOCK_SHOW, UNLOCK_ARM.
- OFF:
  - Display per zone: hot ? 8'h89 : 8'hFF.
  - power_toggle → ON. sel is cleared on entry.
- ON:
  - zone_toggle: sel ^= zone_toggle. Several bits may be set at once.
  - level_inc, only when unlocked: each selected zone below MAX_LEVEL increments. Its hot flag and hot_sec are cleared.
  - level_dec, only when unlocked: each selected zone above 0 decrements. A 1→0 transition sets hot[i] and sets hot_sec[i]=HOT_S.
  - level_inc and level_dec in the same cycle: both ignored.
  - lock_hold when unlocked, sel==0 and all levels 0 → LOCK_ARM.
  - lock_hold when locked → UNLOCK_ARM.
  - power_toggle → OFF. Every zone with level>0 sets hot and hot_sec=HOT_S. All levels are cleared and sel is cleared.
  - Display when locked: all bytes 8'hC7.
  - Display when unlocked: {~sel[i], level[i]==0 && hot[i] ? H : digit(level[i])}.
- LOCK_ARM:
  - level_inc → locked=1, state timer cleared, go to LOCK_SHOW.
  - level_dec, power_toggle or any zone_toggle → ON, nothing else changes.
  - Display as in ON.
- LOCK_SHOW:
  - All bytes 8'hC7. All inputs are ignored.
  - After LOCK_SHOW_S*CLK_HZ cycles → OFF.
- UNLOCK_ARM:
  - level_dec → locked=0, go to ON.
  - level_inc or power_toggle → ON with locked still 1.
  - Display all 8'hC7.
- Input priority within one cycle: power_toggle > lock_hold > zone_toggle > level_inc/dec.
- Lock survives power-off. Only unlock or reset clears it.
- Hot timers run in every state. On each 1 s tick, every hot zone decrements hot_sec. At 1→0, hot[i] clears on the same edge.
- hot_flags = hot. locked = locked register. seg_out is a combinational decode of registers only; there is no input-to-output path.

## Timing
- Reset values:
  - state=OFF, sel=0, levels=0, hot=0, hot_sec=0, locked=0, prescaler=0.
  - seg_out all 8'hFF, hot_flags=0, locked=0.
- Register updates occur on the posedge after the input pulse. seg_out reflects the new values in that same cycle.
- Prescaler:
  - Free-running 0..CLK_HZ-1 from reset.
  - The tick is asserted in the cycle the count equals CLK_HZ-1.
  - The hot duration is therefore (HOT_S-1)*CLK_HZ+1 .. HOT_S*CLK_HZ cycles.
- LOCK_SHOW lasts exactly LOCK_SHOW_S*CLK_HZ cycles, counted from the entry edge.
- Reset mid-operation (e.g. in LOCK_SHOW or with hot zones) returns everything to the reset values immediately. No pending timers survive.
- Level saturates at 0 and at MAX_LEVEL. No wrap.

## Test plan
- Power-on and inc: ZONES=2, CLK_HZ=10. power_toggle, then zone_toggle=01, then level_inc ×12.
  - Expect level0=9 (saturated).
  - Expect seg_out[7:0]=8'h10, seg_out[15:8]=8'hC0.
- Multi-zone dec to hot: select both zones, inc ×2, dec ×2.
  - Expect hot_flags=2'b11 and both bytes 8'h09.
  - After 10 s (100 cycles ±10), hot_flags=0 and bytes 8'h40.
- Power-off residual: zone0 at level 3, power_toggle.
  - Expect OFF state, byte0 8'h89, byte1 8'hFF.
  - After HOT_S seconds, byte0 8'hFF.
- Lock cycle: ON, idle, lock_hold, then level_inc.
  - Expect locked=1 and bytes 8'hC7 for 20 cycles, then OFF with 8'hFF.
  - power_toggle, then level_inc: level unchanged, display 8'hC7.
  - lock_hold, then level_dec: locked=0.
- Abort and simultaneous inputs:
  - In LOCK_ARM, zone_toggle → ON with locked=0.
  - In ON, level_inc with level_dec together → no level change.
  - power_toggle with lock_hold together → OFF.
- Reset mid-LOCK_SHOW with hot zones: assert async_reset low.
  - Expect seg_out all FF, hot_flags=0, locked=0 immediately, no clock edge needed.

Source files
------------

// File: rtl/multi_zone_stove.sv
// Multi-zone stove controller: per-zone power levels, residual-heat timers and a child lock,
// decoded onto one active-low 7-segment digit per zone.
module multi_zone_stove #(
   parameter int ZONES       = 4,
   parameter int MAX_LEVEL   = 9,
   parameter int CLK_HZ      = 50_000_000,
   parameter int LOCK_SHOW_S = 2,
   parameter int HOT_S       = 10
) (
   input  logic               clk,
   input  logic               async_reset,
   input  logic               power_toggle,
   input  logic [ZONES-1:0]   zone_toggle,
   input  logic               level_inc,
   input  logic               level_dec,
   input  logic               lock_hold,
   output logic [8*ZONES-1:0] seg_out,
   output logic [ZONES-1:0]   hot_flags,
   output logic               locked
);

   localparam int HOT_W    = $clog2(HOT_S + 1);
   localparam int PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int SHOW_CYC = LOCK_SHOW_S * CLK_HZ;
   localparam int SHOW_W   = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

   localparam logic [6:0] GLYPH_H     = 7'h09;
   localparam logic [6:0] GLYPH_BLANK = 7'h7F;
   localparam logic [7:0] BYTE_LOCK   = 8'hC7;
   localparam logic [7:0] BYTE_OFF    = 8'hFF;
   localparam logic [7:0] BYTE_HOT    = 8'h89;

   typedef enum logic [2:0] {
      S_OFF,
      S_ON,
      S_LOCK_ARM,
      S_LOCK_SHOW,
      S_UNLOCK_ARM
   } state_t;

   state_t                state, state_nx;
   logic [ZONES-1:0]      sel, sel_nx;
   logic [3:0]            level    [ZONES];
   logic [3:0]            level_nx [ZONES];
   logic [ZONES-1:0]      hot, hot_nx;
   logic [HOT_W-1:0]      hot_sec    [ZONES];
   logic [HOT_W-1:0]      hot_sec_nx [ZONES];
   logic                  locked_nx;
   logic [PRE_W-1:0]      pre_cnt, pre_cnt_nx;
   logic [SHOW_W-1:0]     show_cnt, show_cnt_nx;
   logic                  tick;
   logic                  inc_only, dec_only;
   logic                  lvl_any;
   logic [ZONES-1:0]      hot_set, hot_clr;

   function automatic logic [6:0] digit_glyph(input logic [3:0] v);
      case (v)
         4'd0:    digit_glyph = 7'h40;
         4'd1:    digit_glyph = 7'h79;
         4'd2:    digit_glyph = 7'h24;
         4'd3:    digit_glyph = 7'h30;
         4'd4:    digit_glyph = 7'h19;
         4'd5:    digit_glyph = 7'h12;
         4'd6:    digit_glyph = 7'h02;
         4'd7:    digit_glyph = 7'h78;
         4'd8:    digit_glyph = 7'h00;
         4'd9:    digit_glyph = 7'h10;
         default: digit_glyph = GLYPH_BLANK;
      endcase
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      sat_inc = (v < 4'(MAX_LEVEL)) ? v + 4'd1 : v;
   endfunction

   function automatic logic [3:0] sat_dec(input logic [3:0] v);
      sat_dec = (v != 4'd0) ? v - 4'd1 : v;
   endfunction

   assign tick       = (pre_cnt == PRE_W'(CLK_HZ - 1));
   assign pre_cnt_nx = tick ? '0 : pre_cnt + PRE_W'(1);
   assign inc_only   = level_inc & ~level_dec;
   assign dec_only   = level_dec & ~level_inc;
   assign hot_flags  = hot;

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         state    <= S_OFF;
         sel      <= '0;
         level    <= '{default: '0};
         hot      <= '0;
         hot_sec  <= '{default: '0};
         locked   <= 1'b0;
         pre_cnt  <= '0;
         show_cnt <= '0;
      end else begin
         state    <= state_nx;
         sel      <= sel_nx;
         level    <= level_nx;
         hot      <= hot_nx;
         hot_sec  <= hot_sec_nx;
         locked   <= locked_nx;
         pre_cnt  <= pre_cnt_nx;
         show_cnt <= show_cnt_nx;
      end
   end

   // Next state: only the highest-priority input present in a cycle takes effect.
   always_comb begin
      state_nx    = state;
      sel_nx      = sel;
      level_nx    = level;
      locked_nx   = locked;
      show_cnt_nx = show_cnt;
      hot_set     = '0;
      hot_clr     = '0;
      lvl_any     = 1'b0;
      for (int i = 0; i < ZONES; i++) lvl_any = lvl_any | (level[i] != 4'd0);

      case (state)
         S_OFF: begin
            if (power_toggle) begin
               state_nx = S_ON;
               sel_nx   = '0;
            end
         end
         S_ON: begin
            if (power_toggle) begin
               state_nx = S_OFF;
               sel_nx   = '0;
               for (int i = 0; i < ZONES; i++) begin
                  hot_set[i]  = (level[i] != 4'd0);
                  level_nx[i] = 4'd0;
               end
            end else if (lock_hold) begin
               if (locked)                      state_nx = S_UNLOCK_ARM;
               else if (sel == '0 && !lvl_any)  state_nx = S_LOCK_ARM;
            end else if (zone_toggle != '0) begin
               sel_nx = sel ^ zone_toggle;
            end else if (!locked) begin
               for (int i = 0; i < ZONES; i++) begin
                  if (sel[i] && inc_only && level[i] < 4'(MAX_LEVEL)) begin
                     level_nx[i] = sat_inc(level[i]);
                     hot_clr[i]  = 1'b1;
                  end else if (sel[i] && dec_only && level[i] != 4'd0) begin
                     level_nx[i] = sat_dec(level[i]);
                     hot_set[i]  = (level[i] == 4'd1);
                  end
               end
            end
         end
         S_LOCK_ARM: begin
            if (power_toggle || (!lock_hold && (zone_toggle != '0 || dec_only))) begin
               state_nx = S_ON;
            end else if (!lock_hold && inc_only) begin
               locked_nx   = 1'b1;
               show_cnt_nx = '0;
               state_nx    = S_LOCK_SHOW;
            end
         end
         S_LOCK_SHOW: begin
            if (show_cnt == SHOW_W'(SHOW_CYC - 1)) state_nx = S_OFF;
            else                                  show_cnt_nx = show_cnt + SHOW_W'(1);
         end
         S_UNLOCK_ARM: begin
            if (power_toggle) begin
               state_nx = S_ON;
            end else if (!lock_hold && zone_toggle == '0) begin
               if (dec_only) begin
                  locked_nx = 1'b0;
                  state_nx  = S_ON;
               end else if (inc_only) begin
                  state_nx = S_ON;
               end
            end
         end
         default: state_nx = S_OFF;
      endcase
   end

   // Residual-heat timers run in every state; a fresh power-down restarts the hold.
   always_comb begin
      hot_nx     = hot;
      hot_sec_nx = hot_sec;
      for (int i = 0; i < ZONES; i++) begin
         if (hot_set[i]) begin
            hot_nx[i]     = 1'b1;
            hot_sec_nx[i] = HOT_W'(HOT_S);
         end else if (hot_clr[i]) begin
            hot_nx[i]     = 1'b0;
            hot_sec_nx[i] = '0;
         end else if (tick && hot[i]) begin
            if (hot_sec[i] <= HOT_W'(1)) begin
               hot_nx[i]     = 1'b0;
               hot_sec_nx[i] = '0;
            end else begin
               hot_sec_nx[i] = hot_sec[i] - HOT_W'(1);
            end
         end
      end
   end

   always_comb begin
      seg_out = '1;
      for (int i = 0; i < ZONES; i++) begin
         case (state)
            S_OFF:                    seg_out[8*i +: 8] = hot[i] ? BYTE_HOT : BYTE_OFF;
            S_LOCK_SHOW, S_UNLOCK_ARM: seg_out[8*i +: 8] = BYTE_LOCK;
            default: begin
               if (locked)
                  seg_out[8*i +: 8] = BYTE_LOCK;
               else if (level[i] == 4'd0 && hot[i])
                  seg_out[8*i +: 8] = {~sel[i], GLYPH_H};
               else
                  seg_out[8*i +: 8] = {~sel[i], digit_glyph(level[i])};
            end
         endcase
      end
   end

endmodule
